// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//
// Word-addressed instruction ROM for the MIPS datapath. It takes a byte PC and
// returns the addressed 32-bit instruction word one clock later. Contents start
// as a small built-in program.
//
// Optional feature: define IMEM_PROG_PORT_EN to add a programming write port.
// The memory then becomes writable, and reads are read-before-write on the
// same edge.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset (out/addr_err only)
//   pc         in   32     byte address of the instruction to fetch
//   prog_we    in   1      write enable           (IMEM_PROG_PORT_EN only)
//   prog_addr  in   log2D  word index to write    (IMEM_PROG_PORT_EN only)
//   prog_data  in   32     word to write          (IMEM_PROG_PORT_EN only)
//   out        out  32     fetched instruction word (registered)
//   addr_err   out  1      last fetch was misaligned or out of range (registered)
// -----------------------------------------------------------------------------
module instruction_memory #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc,
`ifdef IMEM_PROG_PORT_EN
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
`endif
    output logic [31:0]              out,
    output logic                     addr_err
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    // Built-in boot program; every word past the program is zero.
    function automatic logic [31:0] boot_word(input logic [AddrW-1:0] idx);
        logic [31:0] w;
        case (int'(idx))
            0:       w = 32'h2008_0005; // addi $t0,$zero,5
            1:       w = 32'h2009_000A; // addi $t1,$zero,10
            2:       w = 32'h0109_5020; // add  $t2,$t0,$t1
            3:       w = 32'h0128_5822; // sub  $t3,$t1,$t0
            4:       w = 32'hAC0A_0000; // sw   $t2,0($zero)
            5:       w = 32'h8C0C_0000; // lw   $t4,0($zero)
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [31:0]      off;
    logic [AddrW-1:0] word_idx;
    logic             in_range;
    logic             misaligned;
    logic [31:0]      rd_data;
    logic [31:0]      out_d, out_q;
    logic             err_d, err_q;

    // Offset wraps modulo 2^32; the pc >= BASE_ADDR term rejects wrapped values.
    assign off        = pc - BASE_ADDR;
    assign word_idx   = off[AddrW+1:2];
    // DEPTH is a power of two, so idx < DEPTH means all upper offset bits are zero.
    assign in_range   = (pc >= BASE_ADDR) && (off[31:AddrW+2] == '0);
    assign misaligned = (pc[1:0] != 2'b00);

    // Byte-lane bits are ignored for the fetch itself.
    logic unused_off;
    assign unused_off = ^off[1:0];

`ifdef IMEM_PROG_PORT_EN
    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t boot_image();
        mem_t img;
        for (int i = 0; i < int'(DEPTH); i++) begin
            img[i] = boot_word(AddrW'(i));
        end
        return img;
    endfunction

    // Power-up contents are loaded at elaboration; reset never touches them.
    mem_t mem_q = boot_image();

    // Writes ignore rst: reset only blocks the fetch registers.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Combinational read of the current contents; the fetch register captures
    // the pre-write value on an edge that also writes the same word.
    assign rd_data = mem_q[word_idx];
`else
    assign rd_data = boot_word(word_idx);
`endif

    always_comb begin
        out_d = 32'h0000_0000;
        err_d = 1'b0;
        if (in_range) begin
            out_d = rd_data;
        end
        if (!in_range || misaligned) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 32'h0000_0000;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign out      = out_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//
// Directed self-checking bench for instruction_memory at default parameters
// (DEPTH=64, BASE_ADDR=0). Inputs change just after a rising edge; outputs are
// sampled 1 time unit after the edge. Programming-port cases are compiled in
// when IMEM_PROG_PORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc  = 32'h0;
    logic [31:0] out;
    logic        addr_err;
`ifdef IMEM_PROG_PORT_EN
    logic        prog_we   = 1'b0;
    logic [5:0]  prog_addr = 6'd0;
    logic [31:0] prog_data = 32'h0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    instruction_memory #(
        .DEPTH     (64),
        .BASE_ADDR (32'h0000_0000)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
`ifdef IMEM_PROG_PORT_EN
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
`endif
        .out       (out),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present pc, take one edge, sample both outputs just after it.
    task automatic fetch(input logic [31:0] addr, input string tag,
                         input logic [31:0] exp_out, input logic exp_err);
        pc = addr;
        @(posedge clk);
        #1;
        check({tag, ".out"}, out, exp_out);
        check({tag, ".err"}, {31'b0, addr_err}, {31'b0, exp_err});
    endtask

    initial begin
        // Reset asserted before the first edge: outputs clear asynchronously.
        #2 rst = 1'b1;
        #1;
        check("rst_async.out", out, 32'h0);
        check("rst_async.err", {31'b0, addr_err}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held.out", out, 32'h0);

        // First fetch happens on the first edge after release.
        rst = 1'b0;
        fetch(32'd0,  "w0", 32'h2008_0005, 1'b0);
        fetch(32'd4,  "w1", 32'h2009_000A, 1'b0);
        fetch(32'd8,  "w2", 32'h0109_5020, 1'b0);
        fetch(32'd12, "w3", 32'h0128_5822, 1'b0);
        fetch(32'd16, "w4", 32'hAC0A_0000, 1'b0);
        fetch(32'd20, "w5", 32'h8C0C_0000, 1'b0);

        // Range boundaries.
        fetch(32'd24,         "w6_zero",   32'h0, 1'b0);
        fetch(32'd252,        "last_word", 32'h0, 1'b0);
        fetch(32'd256,        "oor_depth", 32'h0, 1'b1);
        fetch(32'd8,          "after_oor", 32'h0109_5020, 1'b0);
        fetch(32'hFFFF_FFFC,  "oor_top",   32'h0, 1'b1);

        // Misaligned: data from the truncated index, error flagged.
        fetch(32'd6,  "misal6",  32'h2009_000A, 1'b1);
        fetch(32'd8,  "realign", 32'h0109_5020, 1'b0);
        fetch(32'd19, "misal19", 32'hAC0A_0000, 1'b1);

        // Reset mid-cycle while addr_err is set: both clear with no edge.
        #2 rst = 1'b1;
        #1;
        check("rst_mid_err.out", out, 32'h0);
        check("rst_mid_err.err", {31'b0, addr_err}, 32'h0);
        rst = 1'b0;
        fetch(32'd8, "rel1", 32'h0109_5020, 1'b0);

        // Reset mid-cycle while out holds w2.
        #2 rst = 1'b1;
        #1;
        check("rst_mid.out", out, 32'h0);
        rst = 1'b0;
        fetch(32'd12, "rel2", 32'h0128_5822, 1'b0);

`ifdef IMEM_PROG_PORT_EN
        // Same-edge write and fetch of word 3: old value first, new value next.
        prog_we   = 1'b1;
        prog_addr = 6'd3;
        prog_data = 32'hDEAD_BEEF;
        fetch(32'd12, "rbw_old", 32'h0128_5822, 1'b0);
        prog_we = 1'b0;
        fetch(32'd12, "rbw_new", 32'hDEAD_BEEF, 1'b0);

        // Writes still land while rst is high.
        rst       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 6'd10;
        prog_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("prog_in_rst.out", out, 32'h0);
        prog_we = 1'b0;
        rst     = 1'b0;
        fetch(32'd40, "prog_in_rst", 32'h1234_5678, 1'b0);
        fetch(32'd16, "w4_intact",   32'hAC0A_0000, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
